snn_layer_debug_readout: RTL and testbench

- Reader and serializer for a neuron layer's debug outputs (packed membrane potentials plus output spike vector).
- On a capture request it snapshots both buses atomically and streams them as a fixed-length byte frame over an 8-bit valid/ready port toward the chip's output pins.
- Sits between the delay-neuron layer and the top-level I/O mux; it is the consumer end of the layer's debug interface.

---
 rtl/snn_layer_debug_readout_pkg.sv | 24 ++
 rtl/snn_layer_debug_readout.sv | 144 ++++++++++++++
 tb/tb_snn_layer_debug_readout.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/snn_layer_debug_readout_pkg.sv
`default_nettype none
// ============================================================================
//  Package : snn_debug_pkg
//  Brief   : Shared constants, frame-length helper and FSM state type for the
//            neuron-layer debug readout serializer.
//  Rev     : 1.0  initial release
// ============================================================================
package snn_debug_pkg;

    // Upper nibble of every frame header byte
    localparam logic [3:0] FRAME_HDR_NIBBLE = 4'hA;

    // Frame = header + spike byte + one byte per neuron + checksum
    function automatic int frame_len(input int n);
        return n + 3;
    endfunction

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/snn_layer_debug_readout.sv
`default_nettype none
// ============================================================================
//  Module  : snn_layer_debug_readout
//  Brief   : Snapshots a neuron layer's packed membrane potentials and spike
//            vector on request and streams them as a fixed-length byte frame
//            (header, spikes, membranes, XOR checksum) over a valid/ready port.
//  Rev     : 1.0  initial release
// ============================================================================
module snn_layer_debug_readout
    import snn_debug_pkg::*;
#(
    parameter int N     = 4,
    parameter int Nbits = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 capture,
    input  logic [N*Nbits-1:0]   membrane_potential_in,
    input  logic [N-1:0]         spikes_in,
    input  logic                 out_ready,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overrun
);

    localparam int              L        = frame_len(N);
    localparam int              IDXW     = $clog2(L);
    localparam int              NSLOT    = 2 ** IDXW;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(L - 1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [IDXW-1:0]        r_idx;
    logic [IDXW-1:0]        w_next_idx;
    logic [3:0]             r_seq;
    logic [3:0]             r_frame_seq;
    logic [N*Nbits-1:0]     r_snap_mem;
    logic [N-1:0]           r_snap_spk;
    logic [7:0]             w_csum;
    logic [7:0]             w_bytes [NSLOT];

    assign w_next_idx = r_idx + 1'b1;

    // Frame image built purely from the snapshot, so late input changes never leak in
    always_comb begin
        for (int k = 0; k < NSLOT; k++) begin
            w_bytes[k] = '0;
        end
        w_csum = '0;
        w_bytes[0] = {FRAME_HDR_NIBBLE, r_frame_seq};
        w_bytes[1][N-1:0] = r_snap_spk;
        for (int i = 0; i < N; i++) begin
            w_bytes[i+2][Nbits-1:0] = r_snap_mem[i*Nbits +: Nbits];
        end
        for (int k = 0; k < L - 1; k++) begin
            w_csum = w_csum ^ w_bytes[k];
        end
        w_bytes[L-1] = w_csum;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; valid/busy decode from the state register only
    always_comb begin
        w_next_state = r_state;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                if (capture) begin
                    w_next_state = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready && (r_idx == LAST_IDX)) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Snapshot, sequence counter, byte index and registered output byte mux.
    // frame_done is registered to keep out_ready off any combinational output
    // path, so it rises the cycle after the final handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx       <= '0;
            r_seq       <= '0;
            r_frame_seq <= '0;
            r_snap_mem  <= '0;
            r_snap_spk  <= '0;
            out_data    <= '0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (capture) begin
                        r_snap_mem  <= membrane_potential_in;
                        r_snap_spk  <= spikes_in;
                        r_frame_seq <= r_seq;
                        r_seq       <= r_seq + 4'd1;
                        r_idx       <= '0;
                        out_data    <= {FRAME_HDR_NIBBLE, r_seq};
                    end
                end
                SEND: begin
                    if (capture) begin
                        overrun <= 1'b1;
                    end
                    if (out_ready) begin
                        if (r_idx == LAST_IDX) begin
                            frame_done <= 1'b1;
                            r_idx      <= '0;
                        end else begin
                            r_idx    <= w_next_idx;
                            out_data <= w_bytes[w_next_idx];
                        end
                    end
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_snn_layer_debug_readout.sv
`default_nettype none
// ============================================================================
//  Module  : tb_snn_layer_debug_readout
//  Brief   : Scoreboard bench for snn_layer_debug_readout with a frame-level
//            reference model and randomized data / backpressure.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_snn_layer_debug_readout;

    localparam int N  = 4;
    localparam int NB = 4;
    localparam int L  = N + 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            capture;
    logic [N*NB-1:0] mem;
    logic [N-1:0]    spk;
    logic            out_ready;
    logic [7:0]      out_data;
    logic            out_valid;
    logic            busy;
    logic            frame_done;
    logic            overrun;

    int compared   = 0;
    int mismatched = 0;

    // {last_flag, byte}
    logic [8:0] sbq[$];
    int         tb_seq     = 0;
    int         ready_mode = 0;
    int         vcount     = 0;

    logic       pend_done  = 1'b0;
    logic       stall      = 1'b0;
    logic [7:0] stall_data = '0;

    snn_layer_debug_readout #(.N(N), .Nbits(NB)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .capture               (capture),
        .membrane_potential_in (mem),
        .spikes_in             (spk),
        .out_ready             (out_ready),
        .out_data              (out_data),
        .out_valid             (out_valid),
        .busy                  (busy),
        .frame_done            (frame_done),
        .overrun               (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame from the byte-layout rules
    function automatic void push_frame(input logic [N*NB-1:0] m, input logic [N-1:0] s, input int sq);
        logic [7:0] b[L];
        logic [7:0] x;
        b[0] = 8'hA0 | 8'(sq % 16);
        b[1] = 8'(s);
        for (int i = 0; i < N; i++) begin
            b[i+2] = 8'((m >> (i * NB)) & ((1 << NB) - 1));
        end
        x = 8'h00;
        for (int i = 0; i < L - 1; i++) x = x ^ b[i];
        b[L-1] = x;
        for (int i = 0; i < L; i++) sbq.push_back({(i == L - 1), b[i]});
    endfunction

    function automatic void push_literal(input logic [7:0] b0, b1, b2, b3, b4, b5, b6);
        sbq.push_back({1'b0, b0}); sbq.push_back({1'b0, b1});
        sbq.push_back({1'b0, b2}); sbq.push_back({1'b0, b3});
        sbq.push_back({1'b0, b4}); sbq.push_back({1'b0, b5});
        sbq.push_back({1'b1, b6});
    endfunction

    // Downstream ready generator
    initial begin
        int rcnt = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((rcnt % 3) == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            rcnt++;
        end
    end

    // Monitor: pops the scoreboard on every handshake
    always @(negedge clk) begin
        logic [8:0] e;
        if (reset) begin
            pend_done = 1'b0;
            stall     = 1'b0;
        end else begin
            chk("frame_done", frame_done, pend_done);
            pend_done = 1'b0;
            if (stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, stall_data);
            end
            stall = 1'b0;
            if (out_valid) vcount++;
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_byte: got %0h expected none", out_data);
                end else begin
                    e = sbq.pop_front();
                    chk("frame_byte", out_data, e[7:0]);
                    pend_done = e[8];
                end
            end else if (out_valid) begin
                stall      = 1'b1;
                stall_data = out_data;
            end
        end
    end

    task automatic cap(input logic [N*NB-1:0] m, input logic [N-1:0] s);
        int n = 0;
        while (busy && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (busy) begin
            compared++; mismatched++;
            $display("FAIL idle_timeout: got busy=1 expected busy=0");
        end
        mem = m; spk = s; capture = 1'b1;
        @(posedge clk); #1;
        capture = 1'b0;
        chk("latency_valid", out_valid, 1);
        chk("latency_hdr", out_data, 8'hA0 | 8'(tb_seq % 16));
        tb_seq++;
    endtask

    task automatic send_frame(input logic [N*NB-1:0] m, input logic [N-1:0] s);
        push_frame(m, s, tb_seq);
        cap(m, s);
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || busy) && n < 400) begin
            @(posedge clk); #1; n++;
        end
        if (sbq.size() != 0 || busy) begin
            compared++; mismatched++;
            $display("FAIL drain_timeout: got %0d bytes left expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        reset = 1'b1; capture = 1'b0; mem = '0; spk = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_data", out_data, 0);

        // Basic frame with hard-coded expected bytes
        ready_mode = 0;
        push_literal(8'hA0, 8'h0A, 8'h01, 8'h02, 8'h03, 8'h04, 8'hAE);
        vcount = 0;
        cap(16'h4321, 4'b1010);
        drain();
        repeat (2) @(posedge clk); #1;
        chk("basic_valid_cycles", vcount, 7);

        // Backpressure 1,0,0 pattern
        ready_mode = 1;
        send_frame(16'h4321, 4'b1010);
        drain();

        // Snapshot isolation and dropped capture
        ready_mode = 0;
        send_frame(16'h4321, 4'b1010);
        @(posedge clk); #1;
        mem = 16'hFFFF; capture = 1'b1;
        @(posedge clk); #1;
        capture = 1'b0;
        drain();
        chk("overrun_set", overrun, 1);
        repeat (5) @(posedge clk); #1;
        chk("no_second_frame", out_valid, 0);
        chk("overrun_sticky", overrun, 1);

        // Sequence wrap with random backpressure
        ready_mode = 2;
        for (int f = 0; f < 17; f++) begin
            send_frame('0, '0);
            drain();
        end

        // Reset mid-frame
        ready_mode = 0;
        send_frame(16'h1234, 4'b0110);
        begin
            int n = 0;
            while (sbq.size() > L - 2 && n < 50) begin
                @(posedge clk); #1; n++;
            end
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sbq.delete();
        tb_seq = 0;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_overrun", overrun, 0);
        chk("abort_done", frame_done, 0);

        // Max values, seq restarted at 0
        push_literal(8'hA0, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'hAF);
        cap(16'hFFFF, 4'hF);
        drain();

        // Random frames, inputs scrambled while in flight
        ready_mode = 2;
        for (int f = 0; f < 20; f++) begin
            send_frame(16'($urandom), 4'($urandom));
            mem = 16'($urandom); spk = 4'($urandom);
            drain();
        end
        chk("final_overrun", overrun, 0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
